pcie_cos_arbiter: RTL and testbench

Four-queue class-of-service arbiter sitting directly downstream of the per-class `fifo` instances in the PCIe switching datapath. It pops words from up to four class FIFOs using burst-limited round-robin and pushes them, tagged with their class, into a single downstream FIFO. It honours downstream back-pressure via that FIFO's `almost_full`.

---
 rtl/pcie_cos_arbiter.sv | 96 +++++++++
 tb/tb_pcie_cos_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_cos_arbiter.sv
// Four-queue class-of-service arbiter: burst-limited round-robin pops into one tagged downstream stream.
// Optional COS_STRICT_PRIO_EN: lowest-index non-empty queue always wins (burst limit and rotation ignored).
module pcie_cos_arbiter #(
  parameter int DATA_SIZE = 10,
  parameter int BURST_LEN = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             fifo_empty,
  input  logic [4*DATA_SIZE-1:0] data_out_pop,
  input  logic                   almost_full,
  output logic [3:0]             read,
  output logic                   write,
  output logic [DATA_SIZE-1:0]   data_in_push,
  output logic [1:0]             class_out,
  output logic                   busy,
  output logic                   state_dbg
);

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [1:0] grant;
  logic [1:0] last_q;
  logic [1:0] cur_g;
  logic [3:0] burst_cnt;
  logic       need_rot;
  logic       rd_en;
  logic       rd_valid;
  logic [1:0] rd_class;

  // Handshake: read[g] is a pop commit at the rising edge; the word is presented by the queue
  // for the whole next cycle, and write is a one-cycle push with data_in_push/class_out valid.
  always_comb begin
    cur_g = grant;
`ifdef COS_STRICT_PRIO_EN
    need_rot = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      if (!fifo_empty[k]) cur_g = 2'(k);
    end
`else
    // burst_cnt==0 marks a pending rotation (after reset or after the granted queue drained).
    need_rot = (burst_cnt == 4'd0) || (burst_cnt >= 4'(BURST_LEN)) || fifo_empty[grant];
    if (need_rot) begin
      for (int k = 4; k >= 1; k--) begin
        if (!fifo_empty[2'(last_q + 2'(k))]) cur_g = 2'(last_q + 2'(k));
      end
    end
`endif
  end

  assign rd_en     = (state == SERVE) && !almost_full && !fifo_empty[cur_g];
  assign read      = rd_en ? (4'b0001 << cur_g) : 4'b0000;
  assign busy      = (state == SERVE) || rd_valid || write;
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!(&fifo_empty) && !almost_full) state_nxt = SERVE;
      SERVE:   if ((&fifo_empty) || almost_full) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      grant        <= 2'd0;
      last_q       <= 2'd3;
      burst_cnt    <= 4'd0;
      rd_valid     <= 1'b0;
      rd_class     <= 2'd0;
      write        <= 1'b0;
      data_in_push <= '0;
      class_out    <= 2'd0;
    end else begin
      state    <= state_nxt;
      rd_valid <= rd_en;
      write    <= rd_valid;
      if (rd_en) begin
        rd_class  <= cur_g;
        grant     <= cur_g;
        last_q    <= cur_g;
        burst_cnt <= need_rot ? 4'd1 : burst_cnt + 4'd1;
      end else if (fifo_empty[grant]) begin
        burst_cnt <= 4'd0;
      end
      if (rd_valid) begin
        data_in_push <= data_out_pop[rd_class*DATA_SIZE +: DATA_SIZE];
        class_out    <= rd_class;
      end
    end
  end

endmodule

// File: tb/tb_pcie_cos_arbiter.sv
// Self-checking bench for pcie_cos_arbiter: modelled upstream queues, random back-pressure,
// and an expected-order scoreboard built from the arbitration rules.
module tb_pcie_cos_arbiter;
  localparam int DW = 10;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    fifo_empty = 4'hf;
  logic [4*DW-1:0] data_out_pop = '0;
  logic          almost_full = 1'b0;
  logic [3:0]    read;
  logic          write;
  logic [DW-1:0] data_in_push;
  logic [1:0]    class_out;
  logic          busy;
  logic          state_dbg;

  pcie_cos_arbiter #(.DATA_SIZE(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(rst_n), .fifo_empty(fifo_empty), .data_out_pop(data_out_pop),
    .almost_full(almost_full), .read(read), .write(write), .data_in_push(data_in_push),
    .class_out(class_out), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] mq [4][$];
  logic [DW-1:0] bus_word [4];
  logic [11:0]   exp_q[$];
  int            lat_q[$];
  logic [11:0]   last_out = '0;
  int n_tests = 0, n_fail = 0;
  int cyc = 0, ticks = 0, pend_pop = -1, ref_last = 3;
  int af_pct = 0, pause_after = -1, pause_left = 0, pause_cyc = 0, pause_writes = 0;
  int n_reads = 0, wr_first = -1, wr_last = -1;
  bit check_first = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_queues();
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i] = (mq[i].size() == 0);
      data_out_pop[i*DW +: DW] = bus_word[i];
    end
  endtask

  task automatic load(input int q, input int n);
    for (int k = 0; k < n; k++) mq[q].push_back(DW'($urandom_range(0, 1023)));
  endtask

  // Expected push order from the arbitration rules, given all queue contents up front.
  task automatic build_expected();
    int idx[4];
    int rem[4];
    int total;
    int g;
    int n;
    total = 0;
    for (int i = 0; i < 4; i++) begin
      idx[i] = 0;
      rem[i] = mq[i].size();
      total += rem[i];
    end
    while (total > 0) begin
`ifdef COS_STRICT_PRIO_EN
      g = 0;
      while (rem[g] == 0) g++;
      n = rem[g];
`else
      g = ref_last;
      do g = (g + 1) % 4; while (rem[g] == 0);
      n = (rem[g] < BL) ? rem[g] : BL;
      ref_last = g;
`endif
      for (int k = 0; k < n; k++) begin
        exp_q.push_back({2'(g), mq[g][idx[g]]});
        idx[g]++;
        rem[g]--;
        total--;
      end
    end
  endtask

  task automatic tick();
    logic [11:0] e;
    int g;
    @(negedge clk);
    cyc++;
    ticks++;
    if (pend_pop >= 0) begin
      bus_word[pend_pop] = mq[pend_pop].pop_front();
      pend_pop = -1;
    end
    if (pause_left > 0) begin
      almost_full = 1'b1;
      pause_left--;
      pause_cyc++;
    end else begin
      almost_full = ($urandom_range(0, 99) < af_pct);
      pause_cyc = 0;
    end
    drive_queues();
    #1;
    chk("read_onehot", 32'($countones(read) <= 1), 1);
    chk("read_nonempty", read & fifo_empty, 0);
    if (almost_full) chk("read_paused", read, 0);
    if (read != 4'b0000) begin
      g = 0;
      for (int i = 0; i < 4; i++) if (read[i]) g = i;
      if (check_first) begin
        chk("first_read", read, 4'b0001);
        chk("first_read_delay", ticks, 1);
        check_first = 0;
      end
      pend_pop = g;
      lat_q.push_back(cyc);
      n_reads++;
      if (n_reads == pause_after) pause_left = 5;
    end
    if (write) begin
      if (pause_cyc >= 2) pause_writes++;
      if (wr_first < 0) wr_first = cyc;
      wr_last = cyc;
      if (lat_q.size() == 0) chk("write_without_read", 1, 0);
      else chk("write_latency", cyc - lat_q.pop_front(), 2);
      if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("class_out", class_out, e[11:10]);
        chk("data_in_push", data_in_push, e[9:0]);
      end
      last_out = {class_out, data_in_push};
    end else begin
      chk("output_hold", {class_out, data_in_push}, last_out);
    end
  endtask

  task automatic do_reset(input bit clear_q);
    logic [DW-1:0] tmp;
    @(negedge clk);
    if (pend_pop >= 0) begin
      tmp = mq[pend_pop].pop_front();
      pend_pop = -1;
    end
    if (clear_q) for (int i = 0; i < 4; i++) mq[i].delete();
    almost_full = 1'b0;
    pause_left = 0;
    drive_queues();
    rst_n = 1'b0;
    #1;
    chk("rst_read", read, 0);
    chk("rst_write", write, 0);
    chk("rst_data", data_in_push, 0);
    chk("rst_class", class_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state_dbg, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lat_q.delete();
    ref_last = 3;
    last_out = '0;
    ticks = 0;
  endtask

  task automatic run_scn(input int budget);
    int n;
    n_reads = 0;
    wr_first = -1;
    wr_last = -1;
    pause_writes = 0;
    build_expected();
    n = 0;
    while ((exp_q.size() > 0 || lat_q.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drained", exp_q.size(), 0);
    exp_q.delete();
    lat_q.delete();
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_state", state_dbg, 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) bus_word[i] = '0;

    // Reset with data present, then queues 0 and 2 with six words each, no back-pressure.
    load(0, 6);
    load(2, 6);
    do_reset(0);
    check_first = 1;
    af_pct = 0;
    run_scn(200);
    chk("write_span", wr_last - wr_first, 11);

    // Only queue 3 holds data.
    load(3, 3);
    run_scn(100);

    // Pause after two queue-1 reads, resume five cycles later.
    do_reset(1);
    load(1, 6);
    load(2, 3);
    pause_after = 2;
    run_scn(200);
    chk("pause_writes", pause_writes, 1);
    pause_after = -1;

    // Reset one cycle after a read: the in-flight word must be dropped.
    load(0, 3);
    for (int k = 0; k < 10 && read == 4'b0000; k++) tick();
    chk("mid_read_seen", n_reads > 0 || lat_q.size() > 0, 1);
    do_reset(1);
    repeat (6) tick();
    chk("mid_busy", busy, 0);
    chk("mid_state", state_dbg, 0);

    // Queues 0 and 1 with five words each.
    load(0, 5);
    load(1, 5);
    run_scn(200);

    // Randomized contents, back-pressure and occasional resets.
    for (int s = 0; s < 12; s++) begin
      if ($urandom_range(0, 2) == 0) do_reset(0);
      for (int q = 0; q < 4; q++) load(q, $urandom_range(0, 7));
      af_pct = $urandom_range(0, 40);
      run_scn(400);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
